// File: rtl/tl45_pkg.sv
// Shared TL45 pipeline definitions: fetch FSM states, the NOP bubble encoding
// and PC arithmetic helpers reused by decode and later stages.
package tl45_pkg;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/tl45_skid_buf.sv
// One-entry pc+instruction holding register used when an ack lands while the
// pipeline is stalled; clear takes priority over load.
module tl45_skid_buf
  import tl45_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (i_clear) begin
      valid_d = 1'b0;
      pc_d    = NOP_INST;
      inst_d  = NOP_INST;
    end else if (i_load) begin
      valid_d = 1'b1;
      pc_d    = i_pc;
      inst_d  = i_inst;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q <= 1'b0;
      pc_q    <= NOP_INST;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign o_valid = valid_q;
  assign o_pc    = pc_q;
  assign o_inst  = inst_q;

endmodule

// File: rtl/tl45_prefetch.sv
// TL45 instruction fetch: single-outstanding pipelined Wishbone reads feeding
// the decode buffer, with stall skid, flush/redirect abort and sticky fault halt.
module tl45_prefetch
  import tl45_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned AW       = 30
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_pipe_stall,
  input  logic          i_pipe_flush,
  input  logic          i_new_pc,
  input  logic [31:0]   i_new_pc_addr,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data,
  output logic [31:0]   o_buf_pc,
  output logic [31:0]   o_buf_inst,
  output logic          o_fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         cyc_q, cyc_d;
  logic         stb_q, stb_d;
  logic         err_q, err_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  buf_inst_q, buf_inst_d;

  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_pc, skid_inst;
  logic         redirect;

  tl45_skid_buf u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (skid_load),
    .i_clear   (skid_clear),
    .i_pc      (fetch_pc_q),
    .i_inst    (i_wb_data),
    .o_valid   (skid_valid),
    .o_pc      (skid_pc),
    .o_inst    (skid_inst)
  );

  assign redirect = i_pipe_flush | i_new_pc;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    err_d      = err_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (state_q == S_HALT) begin
      cyc_d      = 1'b0;
      stb_d      = 1'b0;
      buf_pc_d   = NOP_INST;
      buf_inst_d = NOP_INST;
    end else if (redirect) begin
      // Drop cyc for one cycle so the slave sees the abort before re-issuing.
      cyc_d      = 1'b0;
      stb_d      = 1'b0;
      buf_pc_d   = NOP_INST;
      buf_inst_d = NOP_INST;
      skid_clear = 1'b1;
      state_d    = S_ISSUE;
      if (i_new_pc) begin
        fetch_pc_d = i_new_pc_addr;
        if (pc_misaligned(i_new_pc_addr)) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      end else if (skid_valid) begin
        fetch_pc_d = skid_pc;
      end
    end else if (i_wb_err && cyc_q && (state_q == S_ISSUE || state_q == S_WAIT)) begin
      err_d      = 1'b1;
      state_d    = S_HALT;
      cyc_d      = 1'b0;
      stb_d      = 1'b0;
      buf_pc_d   = NOP_INST;
      buf_inst_d = NOP_INST;
    end else begin
      case (state_q)
        S_ISSUE: begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          if (stb_q && !i_wb_stall) begin
            state_d = S_WAIT;
            stb_d   = 1'b0;
          end
          if (!i_pipe_stall) begin
            buf_pc_d   = NOP_INST;
            buf_inst_d = NOP_INST;
          end
        end
        S_WAIT: begin
          cyc_d = 1'b1;
          stb_d = 1'b0;
          if (i_wb_ack) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            if (!i_pipe_stall) begin
              buf_pc_d   = fetch_pc_q;
              buf_inst_d = i_wb_data;
              state_d    = S_ISSUE;
              stb_d      = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = S_HOLD;
              cyc_d     = 1'b0;
            end
          end else if (!i_pipe_stall) begin
            buf_pc_d   = NOP_INST;
            buf_inst_d = NOP_INST;
          end
        end
        S_HOLD: begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (!i_pipe_stall) begin
            buf_pc_d   = skid_pc;
            buf_inst_d = skid_inst;
            skid_clear = 1'b1;
            state_d    = S_ISSUE;
            cyc_d      = 1'b1;
            stb_d      = 1'b1;
          end
        end
        default: begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_ISSUE;
      fetch_pc_q <= RESET_PC;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      buf_pc_q   <= NOP_INST;
      buf_inst_q <= NOP_INST;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = 1'b0;
  assign o_wb_sel    = 4'hF;
  assign o_wb_addr   = fetch_pc_q[AW+1:2];
  assign o_buf_pc    = buf_pc_q;
  assign o_buf_inst  = buf_inst_q;
  assign o_fetch_err = err_q;

endmodule

// File: tb/tb_tl45_prefetch.sv
// Self-checking bench for tl45_prefetch: zero-wait Wishbone slave model plus
// a scoreboard of expected delivery PCs popped whenever decode takes an instruction.
module tb_tl45_prefetch;
  import tl45_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_pipe_stall = 1'b0;
  logic        i_pipe_flush = 1'b0;
  logic        i_new_pc = 1'b0;
  logic [31:0] i_new_pc_addr = 32'h0;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [29:0] o_wb_addr;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall = 1'b0;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_err = 1'b0;
  logic [31:0] i_wb_data = 32'h0;
  logic [31:0] o_buf_pc, o_buf_inst;
  logic        o_fetch_err;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  logic [29:0] acc_log[$];
  logic        err_arm = 1'b0;
  logic [29:0] err_word = 30'h0;

  tl45_prefetch #(.RESET_PC(32'h0), .AW(30)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_pipe_stall  (i_pipe_stall),
    .i_pipe_flush  (i_pipe_flush),
    .i_new_pc      (i_new_pc),
    .i_new_pc_addr (i_new_pc_addr),
    .o_wb_cyc      (o_wb_cyc),
    .o_wb_stb      (o_wb_stb),
    .o_wb_we       (o_wb_we),
    .o_wb_addr     (o_wb_addr),
    .o_wb_sel      (o_wb_sel),
    .i_wb_stall    (i_wb_stall),
    .i_wb_ack      (i_wb_ack),
    .i_wb_err      (i_wb_err),
    .i_wb_data     (i_wb_data),
    .o_buf_pc      (o_buf_pc),
    .o_buf_inst    (o_buf_inst),
    .o_fetch_err   (o_fetch_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    return {8'h0A + w[7:0], 24'h0};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (acc_log.size() > i) return {2'b00, acc_log[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic flush, input logic newpc,
                               input logic [31:0] addr);
    i_pipe_stall  = stall;
    i_pipe_flush  = flush;
    i_new_pc      = newpc;
    i_new_pc_addr = addr;
  endtask

  // One clock: the slave acks (or errors) the cycle after it accepts a request,
  // and every unstalled non-bubble output counts as a delivery to decode.
  task automatic tick();
    logic        acc;
    logic [29:0] a;
    logic        pre_stall;
    logic [31:0] exp_pc;
    acc       = i_reset_n && o_wb_cyc && o_wb_stb && !i_wb_stall;
    a         = o_wb_addr;
    pre_stall = i_pipe_stall;
    @(posedge i_clk);
    #1;
    if (acc) acc_log.push_back(a);
    i_wb_ack  = acc && !(err_arm && a == err_word);
    i_wb_err  = acc && err_arm && a == err_word;
    i_wb_data = acc ? mem_word(a) : 32'hDEAD_BEEF;
    if (i_reset_n && !pre_stall && o_buf_inst != NOP_INST) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", o_buf_inst, NOP_INST);
      end else begin
        exp_pc = sb.pop_front();
        checkOutput("sb_pc", o_buf_pc, exp_pc);
        checkOutput("sb_inst", o_buf_inst, mem_word(exp_pc[31:2]));
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, sb.size(), 0);
  endtask

  initial begin
    int n;
    #1;
    checkOutput("rst_cyc", o_wb_cyc, 0);
    checkOutput("rst_stb", o_wb_stb, 0);
    checkOutput("rst_buf_pc", o_buf_pc, 0);
    checkOutput("rst_buf_inst", o_buf_inst, 0);
    checkOutput("rst_err", o_fetch_err, 0);
    checkOutput("rst_we_sel", {o_wb_we, o_wb_sel}, 5'h0F);
    tick();
    tick();

    // Sequential fetch from RESET_PC with a zero-wait slave
    i_reset_n = 1'b1;
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    n = 0;
    while (!o_wb_stb && n < 5) begin
      tick();
      n++;
    end
    checkOutput("first_addr", o_wb_addr, 0);
    tick();
    tick();
    checkOutput("lat_pc", o_buf_pc, 32'h0);
    checkOutput("lat_inst", o_buf_inst, 32'h0A00_0000);
    drain("p1_drain", 20);
    applyStimulus(1, 0, 0, 0);
    checkOutput("p1_addr0", log_at(0), 0);
    checkOutput("p1_addr1", log_at(1), 1);

    // Pipeline stall while an ack arrives: output holds, skid delivers after release
    acc_log.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("p2_hold_pc", o_buf_pc, 32'h4);
      checkOutput("p2_hold_inst", o_buf_inst, 32'h0B00_0000);
    end
    checkOutput("p2_hold_cyc", o_wb_cyc, 0);
    sb.push_back(32'h8);
    sb.push_back(32'hC);
    applyStimulus(0, 0, 0, 0);
    drain("p2_drain", 20);
    applyStimulus(1, 0, 0, 0);
    checkOutput("p2_nreq", acc_log.size(), 2);
    checkOutput("p2_req0", log_at(0), 2);
    checkOutput("p2_req1", log_at(1), 3);

    // Redirect coinciding with an ack: data dropped, dead cycle, refetch at 0x100
    for (int i = 0; i < 3; i++) tick();
    sb.push_back(32'h10);
    applyStimulus(0, 0, 0, 0);
    n = 0;
    while (!i_wb_ack && n < 10) begin
      tick();
      n++;
    end
    checkOutput("p3_ack_seen", i_wb_ack, 1);
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    applyStimulus(0, 0, 1, 32'h100);
    tick();
    acc_log.delete();
    applyStimulus(0, 0, 0, 0);
    checkOutput("p3_dead_cyc", o_wb_cyc, 0);
    checkOutput("p3_dead_stb", o_wb_stb, 0);
    checkOutput("p3_bubble", o_buf_inst, 0);
    tick();
    checkOutput("p3_stb", o_wb_stb, 1);
    checkOutput("p3_addr", o_wb_addr, 32'h40);
    drain("p3_drain", 20);
    applyStimulus(1, 0, 0, 0);
    checkOutput("p3_req0", log_at(0), 32'h40);

    // Slave stalls the request for four cycles
    for (int i = 0; i < 3; i++) tick();
    sb.push_back(32'h108);
    applyStimulus(0, 0, 0, 0);
    i_wb_stall = 1'b1;
    tick();
    acc_log.delete();
    for (int i = 0; i < 4; i++) begin
      checkOutput("p4_stb", o_wb_stb, 1);
      checkOutput("p4_addr", o_wb_addr, 32'h43);
      tick();
      checkOutput("p4_bubble", o_buf_inst, 0);
    end
    i_wb_stall = 1'b0;
    tick();
    checkOutput("p4_nreq", acc_log.size(), 1);
    checkOutput("p4_req0", log_at(0), 32'h43);
    sb.push_back(32'h10C);
    sb.push_back(32'h110);
    drain("p4_drain", 20);
    applyStimulus(1, 0, 0, 0);

    // Flush while holding a skid entry rewinds to the skid pc
    for (int i = 0; i < 3; i++) tick();
    checkOutput("p6b_hold_cyc", o_wb_cyc, 0);
    applyStimulus(1, 1, 0, 0);
    tick();
    checkOutput("p6b_flush_inst", o_buf_inst, 0);
    checkOutput("p6b_flush_pc", o_buf_pc, 0);
    checkOutput("p6b_flush_cyc", o_wb_cyc, 0);
    sb.push_back(32'h114);
    sb.push_back(32'h118);
    applyStimulus(0, 0, 0, 0);
    tick();
    checkOutput("p6b_stb", o_wb_stb, 1);
    checkOutput("p6b_addr", o_wb_addr, 32'h45);
    drain("p6b_drain", 20);

    // Bus error on the fetch of pc 8 halts fetch until reset
    err_arm  = 1'b1;
    err_word = 30'h2;
    applyStimulus(1, 0, 1, 32'h8);
    tick();
    applyStimulus(0, 0, 0, 0);
    n = 0;
    while (!o_fetch_err && n < 10) begin
      tick();
      n++;
    end
    checkOutput("p5_err", o_fetch_err, 1);
    checkOutput("p5_cyc", o_wb_cyc, 0);
    checkOutput("p5_bubble", o_buf_inst, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i[0], 0, i == 1, 32'h200);
      tick();
      checkOutput("p5_halt_cyc", o_wb_cyc, 0);
      checkOutput("p5_halt_err", o_fetch_err, 1);
      checkOutput("p5_halt_inst", o_buf_inst, 0);
    end
    applyStimulus(0, 0, 0, 0);
    #2;
    i_reset_n = 1'b0;
    #1;
    checkOutput("p5_rst_cyc", o_wb_cyc, 0);
    checkOutput("p5_rst_stb", o_wb_stb, 0);
    checkOutput("p5_rst_err", o_fetch_err, 0);
    checkOutput("p5_rst_pc", o_buf_pc, 0);
    checkOutput("p5_rst_addr", o_wb_addr, 0);
    tick();
    err_arm = 1'b0;
    acc_log.delete();
    i_reset_n = 1'b1;
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    drain("p5_drain", 20);
    applyStimulus(1, 0, 0, 0);
    checkOutput("p5_refetch", log_at(0), 0);

    // Misaligned redirect faults without starting a bus cycle
    for (int i = 0; i < 3; i++) tick();
    acc_log.delete();
    applyStimulus(1, 0, 1, 32'h102);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("p6_err", o_fetch_err, 1);
    checkOutput("p6_bubble", o_buf_inst, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("p6_cyc", o_wb_cyc, 0);
    end
    checkOutput("p6_nobus", acc_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl45_prefetch.md
Name: tl45_prefetch

Overview:
Instruction fetch stage of the TL45 pipeline. It is the producer that feeds the decode stage's i_buf_pc/i_buf_inst buffer. It issues single-outstanding Wishbone (pipelined) reads to instruction memory, advances the PC, and honours pipeline stall, flush and branch redirect. When no instruction is ready it injects the all-zero NOP bubble, which decode accepts as a legal NOP.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be 0
AW, 30, Wishbone word-address width

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_pipe_stall  in  1  downstream stall; output buffer must hold
i_pipe_flush  in  1  discard buffered/in-flight instruction
i_new_pc  in  1  redirect strobe; qualifies i_new_pc_addr
i_new_pc_addr  in  32  redirect target (byte address)
o_wb_cyc  out  1  bus cycle active
o_wb_stb  out  1  request strobe
o_wb_we  out  1  tied 0
o_wb_addr  out  AW  word address = fetch_pc[31:2]
o_wb_sel  out  4  tied 4'hF
i_wb_stall  in  1  slave not accepting request
i_wb_ack  in  1  read data valid
i_wb_err  in  1  bus error
i_wb_data  in  32  read data
o_buf_pc  out  32  PC of o_buf_inst (0 for bubble)
o_buf_inst  out  32  instruction to decode (0 = bubble)
o_fetch_err  out  1  sticky fetch fault

Behaviour:
- Reset (i_reset_n=0, async): fetch_pc=RESET_PC; state=S_ISSUE; o_wb_cyc/o_wb_stb=0; o_buf_pc/o_buf_inst=0; skid empty; o_fetch_err=0. The first request is issued in the first cycle after reset deasserts.
- States:
  - S_ISSUE: cyc=1, stb=1. Goes to S_WAIT when !i_wb_stall.
  - S_WAIT: cyc=1, stb=0. Waits for ack or err.
  - S_HOLD: cyc=0. Skid buffer full, waiting for !i_pipe_stall.
  - S_HALT: cyc=0. Entered after an error; left only by reset.
- Only one request is outstanding at a time. An ack arriving outside S_WAIT is ignored.
- Ack in S_WAIT with !i_pipe_stall: o_buf_inst<=i_wb_data, o_buf_pc<=fetch_pc, fetch_pc+=4, state=S_ISSUE. Total latency is ISSUE→buffer in 2 cycles minimum (zero-wait slave).
- Ack in S_WAIT with i_pipe_stall: data and pc go to the skid register, fetch_pc+=4, state=S_HOLD. Output registers keep their prior value.
- S_HOLD and !i_pipe_stall: output<=skid, skid empty, state=S_ISSUE.
- Any cycle with !i_pipe_stall and no instruction delivered: output<=0/0 (bubble).
- Any cycle with i_pipe_stall: o_buf_* unchanged, except on flush or redirect.
- i_pipe_flush or i_new_pc (highest priority below reset):
  - output and skid are cleared;
  - cyc/stb drop the next cycle, aborting any in-flight request; a same-cycle ack is discarded;
  - state=S_ISSUE one cycle later (one dead cycle with cyc=0 so the slave sees the abort).
  - With i_new_pc: fetch_pc<=i_new_pc_addr. With flush only: fetch_pc is rewound to the pc of the discarded in-flight/skid instruction, or else left unchanged.
- i_new_pc_addr[1:0]!=0: o_fetch_err<=1, state=S_HALT, output=bubble.
- i_wb_err in S_WAIT or S_ISSUE: o_fetch_err<=1, cyc=0, state=S_HALT. Only bubbles are output after that.
- PC arithmetic is 32-bit and wraps from 32'hFFFF_FFFC to 0 silently.
- Simultaneous i_new_pc and i_wb_err: redirect wins and the error is discarded.

Decomposition:
- Shared package tl45_pkg: typedef of fetch state enum; constants NOP_INST=32'h0 and PC_STEP=4. Decode and later stages reuse NOP_INST.
- One optional sub-module, tl45_skid_buf (1-entry pc+inst register with valid). Otherwise the block is a flat FSM plus datapath.

Test Plan:
1. Reset deassert, zero-wait slave returning 0x0A000000 for mem[0], 0x0B000000 for mem[4] → o_wb_addr 0 then 1; o_buf_pc/inst = 0/0x0A000000, then 4/0x0B000000.
2. Hold i_pipe_stall 3 cycles while ack arrives → o_buf_* unchanged during stall. After release: pc 4/inst from skid, with no lost or duplicated instruction.
3. i_new_pc=1, addr=0x100, same cycle as an ack → acked data dropped, one cyc=0 cycle, next request o_wb_addr=0x40, output bubble meanwhile.
4. i_wb_stall high 4 cycles in S_ISSUE → stb held with a stable address, bubbles output, request accepted on the 5th cycle.
5. i_wb_err on the request for pc 8 → o_fetch_err=1 sticky, cyc=0 forever, bubbles; i_reset_n pulse low mid-state → all outputs 0 immediately, refetch at RESET_PC.
6. Redirect to 0x102 → o_fetch_err=1, S_HALT, no bus cycle issued; flush-only during S_HOLD at pc 12 → refetch o_wb_addr=3.
